// File: rtl/ibr128_subtractor.sv
// Purpose : 128-bit pipelined subtractor, D = A - B mod 2^W, built as an
//           N-stage SLICE_W-bit borrow chain with input skew / output deskew.
// Latency : result for a pair accepted at Enable edge t is registered at
//           Enable edge t+N (8 for the default 128/16 split).
// Backpressure: none; one pair may be accepted per Enable-high cycle.
//           Enable=0 freezes every register (a global stall, not flow control).
//
// Ports:
//   Clk        clock, all state on the rising edge
//   Rst        synchronous active-high reset; wins over Enable/InValid
//   Enable     global advance; low holds the whole pipeline
//   InValid    A/B presented this cycle (accepted when Enable=1)
//   A, B       unsigned minuend / subtrahend, W bits
//   OutValid   D/BorrowOut hold a completed result
//   D          A - B mod 2^W
//   BorrowOut  1 when A < B (unsigned)
//   Busy       any valid pair in flight, including the output register

module ibr128_subtractor #(
  parameter int W       = 128,
  parameter int SLICE_W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Enable,
  input  logic         InValid,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         OutValid,
  output logic [W-1:0] D,
  output logic         BorrowOut,
  output logic         Busy
);

  localparam int N = W / SLICE_W;

  // Registered borrow-out of every stage; stage k consumes brw[k-1] one
  // edge after stage k-1 produced it, which is exactly when slice k of the
  // same pair arrives thanks to the input skew.
  logic [N-1:0] brw;

  // Slice differences after deskew: all N slices of one pair line up here
  // in the same cycle, ready for the output register.
  logic [W-1:0] d_aligned;

  // Valid tag shift register; bit N-1 feeds OutValid on the next edge, so
  // the tag travels in lock-step with stage N-1 of the datapath.
  logic [N-1:0] vld_sr;

  for (genvar k = 0; k < N; k++) begin : g_slice
    logic [SLICE_W-1:0] a_in;
    logic [SLICE_W-1:0] b_in;
    logic               borrow_in;
    logic [SLICE_W:0]   diff;
    logic [SLICE_W-1:0] d_stg;
    logic               brw_stg;

    // ---------------- input skew: slice k waits k edges ----------------
    if (k == 0) begin : g_noskew
      assign a_in = A[SLICE_W-1:0];
      assign b_in = B[SLICE_W-1:0];
    end else begin : g_skew
      // Packed delay line: the newest slice enters at the bottom, the
      // oldest (k edges old) sits in the top slot and feeds the stage.
      logic [k*SLICE_W-1:0] a_dly;
      logic [k*SLICE_W-1:0] b_dly;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          a_dly <= '0;
          b_dly <= '0;
        end else if (Enable) begin
          // Size cast drops the oldest slice off the top.
          a_dly <= (k*SLICE_W)'({a_dly, A[k*SLICE_W +: SLICE_W]});
          b_dly <= (k*SLICE_W)'({b_dly, B[k*SLICE_W +: SLICE_W]});
        end
      end

      assign a_in = a_dly[k*SLICE_W-1 -: SLICE_W];
      assign b_in = b_dly[k*SLICE_W-1 -: SLICE_W];
    end

    // ---------------- borrow chain ----------------
    if (k == 0) begin : g_bin_zero
      assign borrow_in = 1'b0;
    end else begin : g_bin_chain
      assign borrow_in = brw[k-1];
    end

    // Zero-extended subtract: the MSB of the 17-bit result is set exactly
    // when a_in < b_in + borrow_in, i.e. it is the slice's borrow-out.
    always_comb begin
      diff = {1'b0, a_in} - {1'b0, b_in} - {{SLICE_W{1'b0}}, borrow_in};
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        d_stg   <= '0;
        brw_stg <= 1'b0;
      end else if (Enable) begin
        d_stg   <= diff[SLICE_W-1:0];
        brw_stg <= diff[SLICE_W];
      end
    end

    assign brw[k] = brw_stg;

    // ---------------- output deskew: slice k waits N-1-k edges ----------------
    if (k == N-1) begin : g_nodeskew
      assign d_aligned[k*SLICE_W +: SLICE_W] = d_stg;
    end else begin : g_deskew
      logic [(N-1-k)*SLICE_W-1:0] d_dly;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          d_dly <= '0;
        end else if (Enable) begin
          d_dly <= ((N-1-k)*SLICE_W)'({d_dly, d_stg});
        end
      end

      assign d_aligned[k*SLICE_W +: SLICE_W] = d_dly[(N-1-k)*SLICE_W-1 -: SLICE_W];
    end
  end

  // ---------------- valid tag ----------------
  // Bubbles (InValid=0) enter as zeros so result spacing matches input spacing.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_sr <= '0;
    end else if (Enable) begin
      vld_sr <= {vld_sr[N-2:0], InValid};
    end
  end

  // ---------------- output register ----------------
  // D and BorrowOut update on every Enable edge, bubbles included; their
  // value only means something while OutValid is high.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      OutValid  <= 1'b0;
      D         <= '0;
      BorrowOut <= 1'b0;
    end else if (Enable) begin
      OutValid  <= vld_sr[N-1];
      D         <= d_aligned;
      BorrowOut <= brw[N-1];
    end
  end

  // Busy covers the output register too, so it stays high for the cycle a
  // result is presented and drops once nothing valid remains anywhere.
  assign Busy = (|vld_sr) | OutValid;

endmodule

// File: tb/tb_ibr128_subtractor.sv
module tb_ibr128_subtractor;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Enable;
  logic         InValid;
  logic [127:0] A;
  logic [127:0] B;
  logic         OutValid;
  logic [127:0] D;
  logic         BorrowOut;
  logic         Busy;

  ibr128_subtractor #(.W(128), .SLICE_W(16)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Enable    (Enable),
    .InValid   (InValid),
    .A         (A),
    .B         (B),
    .OutValid  (OutValid),
    .D         (D),
    .BorrowOut (BorrowOut),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: every Enable-high edge pushes one entry (valid or
  // bubble) into a queue; the entry pushed 8 Enable edges earlier is what
  // the output shows.
  typedef struct {
    logic         valid;
    logic [127:0] d;
    logic         bo;
  } ent_t;

  ent_t q[$];
  ent_t mout;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] d;
    logic         bo;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One rising edge with the inputs currently driven; the model is updated
  // from the same inputs, then the DUT is compared #1 after the edge.
  task automatic tick();
    ent_t e;
    logic mbusy;
    @(posedge Clk);
    if (Rst) begin
      q.delete();
      mout = '{valid: 1'b0, d: '0, bo: 1'b0};
    end else if (Enable) begin
      e.valid = InValid;
      e.d     = A - B;
      e.bo    = (A < B);
      q.push_back(e);
      if (q.size() > 8) mout = q.pop_front();
    end
    #1;
    mbusy = mout.valid;
    foreach (q[i]) mbusy = mbusy | q[i].valid;
    chk("model_out_valid", {127'd0, OutValid}, {127'd0, mout.valid});
    chk("model_busy", {127'd0, Busy}, {127'd0, mbusy});
    if (mout.valid) begin
      chk("model_d", D, mout.d);
      chk("model_borrow", {127'd0, BorrowOut}, {127'd0, mout.bo});
    end
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] d_hold;
  logic         ov_hold;
  logic         busy_hold;
  logic         bo_hold;

  initial begin
    tbl[0] = '{a: 128'h1_0000, b: 128'h1, d: 128'hFFFF, bo: 1'b0};
    tbl[1] = '{a: 128'h0, b: 128'h1, d: {128{1'b1}}, bo: 1'b1};
    tbl[2] = '{a: 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
               b: 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, d: 128'h0, bo: 1'b0};
    tbl[3] = '{a: 128'd5, b: 128'd3, d: 128'd2, bo: 1'b0};
    tbl[4] = '{a: 128'h1_0000_0000_0000_0000, b: 128'h1,
               d: 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, bo: 1'b0};
    tbl[5] = '{a: 128'd1, b: 128'd2, d: {128{1'b1}}, bo: 1'b1};
    tbl[6] = '{a: 128'h8000_0000_0000_0000_0000_0000_0000_0000, b: 128'h1,
               d: 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, bo: 1'b0};
    tbl[7] = '{a: {128{1'b1}}, b: 128'h0, d: {128{1'b1}}, bo: 1'b0};
    tbl[8] = '{a: 128'h0, b: {128{1'b1}}, d: 128'h1, bo: 1'b1};

    mout = '{valid: 1'b0, d: '0, bo: 1'b0};

    // ---- reset held 2 cycles with random activity ----
    Rst = 1'b1; Enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      InValid = 1'($urandom_range(0, 1)); A = rnd128(); B = rnd128();
      tick();
      chk("rst_d", D, 128'h0);
      chk("rst_borrow", {127'd0, BorrowOut}, 128'h0);
      chk("rst_out_valid", {127'd0, OutValid}, 128'h0);
      chk("rst_busy", {127'd0, Busy}, 128'h0);
    end
    Rst = 1'b0; InValid = 1'b0;
    tick();
    chk("post_rst_d", D, 128'h0);
    chk("post_rst_borrow", {127'd0, BorrowOut}, 128'h0);
    chk("post_rst_out_valid", {127'd0, OutValid}, 128'h0);
    chk("post_rst_busy", {127'd0, Busy}, 128'h0);

    // ---- table: isolated pairs, exact 8-edge latency, one-cycle OutValid ----
    foreach (tbl[v]) begin
      InValid = 1'b1; A = tbl[v].a; B = tbl[v].b;
      tick();
      InValid = 1'b0; A = rnd128(); B = rnd128();
      for (int i = 1; i <= 8; i++) begin
        tick();
        if (i == 7) chk("tbl_early_valid", {127'd0, OutValid}, 128'h0);
      end
      chk("tbl_out_valid", {127'd0, OutValid}, 128'h1);
      chk("tbl_d", D, tbl[v].d);
      chk("tbl_borrow", {127'd0, BorrowOut}, {127'd0, tbl[v].bo});
      tick();
      chk("tbl_valid_drop", {127'd0, OutValid}, 128'h0);
    end

    // ---- streaming: three back-to-back pairs ----
    for (int v = 3; v <= 5; v++) begin
      InValid = 1'b1; A = tbl[v].a; B = tbl[v].b;
      tick();
    end
    InValid = 1'b0;
    for (int i = 3; i <= 7; i++) tick();
    for (int v = 3; v <= 5; v++) begin
      tick();
      chk("stream_out_valid", {127'd0, OutValid}, 128'h1);
      chk("stream_d", D, tbl[v].d);
      chk("stream_borrow", {127'd0, BorrowOut}, {127'd0, tbl[v].bo});
    end
    tick();
    chk("stream_end_valid", {127'd0, OutValid}, 128'h0);

    // ---- stall: 3 Enable-low cycles starting at edge 4 ----
    InValid = 1'b1; A = tbl[6].a; B = tbl[6].b;
    tick();
    InValid = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    d_hold = D; ov_hold = OutValid; busy_hold = Busy; bo_hold = BorrowOut;
    Enable = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      InValid = 1'b1; A = rnd128(); B = rnd128();
      tick();
      chk("stall_d_frozen", D, d_hold);
      chk("stall_valid_frozen", {127'd0, OutValid}, {127'd0, ov_hold});
      chk("stall_busy_frozen", {127'd0, Busy}, {127'd0, busy_hold});
      chk("stall_borrow_frozen", {127'd0, BorrowOut}, {127'd0, bo_hold});
    end
    Enable = 1'b1; InValid = 1'b0;
    for (int i = 7; i <= 10; i++) tick();
    chk("stall_early_valid", {127'd0, OutValid}, 128'h0);
    tick();
    chk("stall_out_valid", {127'd0, OutValid}, 128'h1);
    chk("stall_d", D, tbl[6].d);
    chk("stall_borrow", {127'd0, BorrowOut}, 128'h0);
    tick();

    // ---- reset mid-flight ----
    for (int i = 0; i < 4; i++) begin
      InValid = 1'b1; A = rnd128(); B = rnd128();
      tick();
    end
    InValid = 1'b0;
    tick();
    Rst = 1'b1; InValid = 1'b1; A = 128'd9; B = 128'd4;
    tick();
    Rst = 1'b0; InValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("midrst_out_valid", {127'd0, OutValid}, 128'h0);
      chk("midrst_busy", {127'd0, Busy}, 128'h0);
    end

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      Rst     = ($urandom_range(0, 99) == 0);
      Enable  = ($urandom_range(0, 3) != 0);
      InValid = 1'($urandom_range(0, 1));
      A       = rnd128();
      case ($urandom_range(0, 3))
        0:       B = A;
        1:       B = A + 128'd1;
        2:       B = {96'd0, $urandom};
        default: B = rnd128();
      endcase
      tick();
    end
    Rst = 1'b0; Enable = 1'b1; InValid = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
